// File: rtl/keccak_axis_tx.sv
// Streams one captured 1600-bit Keccak state as up to 25 64-bit AXIS beats; first beat 1 cycle after load.
// Beats hold stable under TREADY backpressure; a new state is accepted only while idle.
module keccak_axis_tx #(
   parameter int DATA_W = 64,
   parameter int LANES  = 25,
   parameter int CNT_W  = 5
) (
   input  logic                    iSYS_CLK,
   input  logic                    iSYS_RST,
   input  logic                    iST_VALID,
   output logic                    oST_READY,
   input  logic [DATA_W*LANES-1:0] iST_DATA,
   input  logic [CNT_W-1:0]        iST_LANES,
   input  logic [7:0]              iST_LKEEP,
   output logic                    oM_AXIS_TVALID,
   input  logic                    iM_AXIS_TREADY,
   output logic [DATA_W-1:0]       oM_AXIS_TDATA,
   output logic [7:0]              oM_AXIS_TKEEP,
   output logic                    oM_AXIS_TLAST,
   output logic                    oBUSY,
   output logic                    oDONE
);
   typedef enum logic {IDLE, SEND} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] lane_q [LANES];
   logic [DATA_W-1:0] lane_d [LANES];
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  last_q, last_d;
   logic [7:0]        keep_q, keep_d;
   logic              done_q, done_d;
   logic              is_last;

   assign is_last = (cnt_q == last_q);

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      keep_d  = keep_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (iST_VALID) begin
               state_d = SEND;
               cnt_d   = '0;
               keep_d  = iST_LKEEP;
               for (int i = 0; i < LANES; i++) begin
                  lane_d[i] = iST_DATA[i*DATA_W +: DATA_W];
               end
               // Zero or oversized lane counts mean a full-state frame.
               if ((iST_LANES == '0) || (int'(iST_LANES) > LANES)) begin
                  last_d = CNT_W'(LANES - 1);
               end else begin
                  last_d = iST_LANES - 1'b1;
               end
            end
         end
         SEND: begin
            if (iM_AXIS_TREADY) begin
               if (is_last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iSYS_CLK or negedge iSYS_RST) begin
      if (!iSYS_RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= '0;
         keep_q  <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            lane_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         keep_q  <= keep_d;
         done_q  <= done_d;
         lane_q  <= lane_d;
      end
   end

   // All beat outputs derive from registered state; TREADY only steers next-state.
   assign oST_READY      = (state_q == IDLE);
   assign oBUSY          = (state_q == SEND);
   assign oM_AXIS_TVALID = oBUSY;
   assign oM_AXIS_TDATA  = oBUSY ? lane_q[cnt_q] : '0;
   assign oM_AXIS_TKEEP  = oBUSY ? (is_last ? keep_q : 8'hFF) : 8'h00;
   assign oM_AXIS_TLAST  = oBUSY && is_last;
   assign oDONE          = done_q;
endmodule
